// File: rtl/custom_text_editor.sv
// Multi-line text entry buffer: builds NUM_LINES fixed-width lines from
// keyboard bytes, with backspace, newline, clear-all and commit.
module custom_text_editor #(
  parameter int         TEXT_LEN_MAX = 20,
  parameter int         NUM_LINES    = 2,
  parameter logic [7:0] PAD_CHAR     = 8'h00
) (
  input  logic                                clock_27mhz,
  input  logic                                reset_n,
  input  logic                                edit_en,
  input  logic                                button_enter,
  input  logic [7:0]                          ascii,
  input  logic                                ascii_ready,
  output logic [NUM_LINES*TEXT_LEN_MAX*8-1:0] char_array,
  output logic                                char_array_rdy,
  output logic [1:0]                          line_idx,
  output logic [5:0]                          num_char,
  output logic [7:0]                          total_char,
  output logic                                overflow
);

  localparam int         W      = NUM_LINES*TEXT_LEN_MAX*8;
  localparam logic [5:0] MAX_C  = 6'(TEXT_LEN_MAX);
  localparam logic [1:0] LAST_L = 2'(NUM_LINES-1);

  typedef enum logic [1:0] {IDLE, EDIT, DONE} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] chars_q, chars_d;
  logic [5:0]   cnt_q [4];
  logic [5:0]   cnt_d [4];
  logic [1:0]   line_q, line_d;
  logic [5:0]   num_q, num_d;
  logic [7:0]   tot_q, tot_d;
  logic         rdy_q, rdy_d;
  logic         ovf_q, ovf_d;
  logic         clr, printable;
  logic [5:0]   cur;
  logic [7:0]   sum;
  int           wr_slot, bs_slot;

  always_comb begin
    state_d   = state_q;
    chars_d   = chars_q;
    cnt_d     = cnt_q;
    line_d    = line_q;
    rdy_d     = rdy_q;
    ovf_d     = 1'b0;
    clr       = 1'b0;
    cur       = cnt_q[line_q];
    printable = (ascii >= 8'h20) && (ascii <= 8'h7E);
    wr_slot   = ((NUM_LINES-1-int'(line_q))*TEXT_LEN_MAX
                + (TEXT_LEN_MAX-1-int'(cur)))*8;
    bs_slot   = wr_slot + 8;
    unique case (state_q)
      IDLE: begin
        clr   = 1'b1;
        rdy_d = 1'b0;
        if (edit_en) state_d = EDIT;
      end
      EDIT: begin
        if (!edit_en) begin
          clr     = 1'b1;
          state_d = IDLE;
        end else if (button_enter) begin
          state_d = DONE;
          rdy_d   = 1'b1;
        end else if (ascii_ready) begin
          unique case (1'b1)
            printable: begin
              if (cur < MAX_C) begin
                chars_d[wr_slot +: 8] = ascii;
                cnt_d[line_q]         = cur + 6'd1;
              end else begin
                ovf_d = 1'b1;
              end
            end
            ascii == 8'h08: begin
              if (cur != 6'd0) begin
                cnt_d[line_q]         = cur - 6'd1;
                chars_d[bs_slot +: 8] = PAD_CHAR;
              end else if (line_q != 2'd0) begin
                line_d = line_q - 2'd1;
              end
            end
            ascii == 8'h0D: begin
              if (line_q < LAST_L) line_d = line_q + 2'd1;
            end
            ascii == 8'h1B: clr = 1'b1;
            default: ;
          endcase
        end
      end
      DONE: begin
        if (!edit_en) begin
          clr     = 1'b1;
          rdy_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      chars_d = {(NUM_LINES*TEXT_LEN_MAX){PAD_CHAR}};
      for (int i = 0; i < 4; i++) cnt_d[i] = 6'd0;
      line_d = 2'd0;
    end
    num_d = cnt_d[line_d];
    // Sum of the pre-edge counts: total lags the buffer by one cycle
    sum = 8'd0;
    for (int i = 0; i < 4; i++) sum = sum + {2'b00, cnt_q[i]};
    tot_d = (state_d == IDLE) ? 8'd0 : sum;
  end

  always_ff @(posedge clock_27mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      chars_q <= {(NUM_LINES*TEXT_LEN_MAX){PAD_CHAR}};
      cnt_q   <= '{default: 6'd0};
      line_q  <= 2'd0;
      num_q   <= 6'd0;
      tot_q   <= 8'd0;
      rdy_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chars_q <= chars_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      num_q   <= num_d;
      tot_q   <= tot_d;
      rdy_q   <= rdy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign char_array     = chars_q;
  assign char_array_rdy = rdy_q;
  assign line_idx       = line_q;
  assign num_char       = num_q;
  assign total_char     = tot_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_custom_text_editor.sv
// Scoreboard bench for custom_text_editor: a byte-array reference model
// pushes expected snapshots, each scenario pops and compares them.
module tb_custom_text_editor;

  localparam int TL = 20;
  localparam int NL = 2;
  localparam int W  = NL*TL*8;

  typedef logic [W+17:0] snap_t;
  typedef struct packed {
    logic       en;
    logic       be;
    logic       ar;
    logic [7:0] a;
  } step_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         edit_en, button_enter, ascii_ready;
  logic [7:0]   ascii;
  logic [W-1:0] char_array;
  logic         char_array_rdy, overflow;
  logic [1:0]   line_idx;
  logic [5:0]   num_char;
  logic [7:0]   total_char;

  always #5 clk = ~clk;

  custom_text_editor #(
    .TEXT_LEN_MAX(TL), .NUM_LINES(NL), .PAD_CHAR(8'h00)
  ) dut (
    .clock_27mhz(clk), .reset_n(rst_n), .edit_en(edit_en),
    .button_enter(button_enter), .ascii(ascii),
    .ascii_ready(ascii_ready), .char_array(char_array),
    .char_array_rdy(char_array_rdy), .line_idx(line_idx),
    .num_char(num_char), .total_char(total_char),
    .overflow(overflow)
  );

  snap_t sb[$];
  int    n_vec = 0;
  int    n_bad = 0;

  logic [7:0] mch [NL][TL];
  int         mcnt [NL];
  int         mline, mstate, mtot;
  bit         mrdy, mov;

  function automatic void m_clear();
    foreach (mch[i, j]) mch[i][j] = 8'h00;
    foreach (mcnt[i]) mcnt[i] = 0;
    mline = 0;
  endfunction

  function automatic void m_reset();
    m_clear();
    mstate = 0; mtot = 0; mrdy = 0; mov = 0;
  endfunction

  function automatic snap_t m_snap();
    logic [W-1:0] ca;
    ca = '0;
    for (int l = 0; l < NL; l++)
      for (int k = 0; k < TL; k++)
        ca[((NL-1-l)*TL + (TL-1-k))*8 +: 8] = mch[l][k];
    return {ca, 2'(mline), 6'(mcnt[mline]), 8'(mtot), mrdy, mov};
  endfunction

  function automatic snap_t obs();
    return {char_array, line_idx, num_char, total_char,
            char_array_rdy, overflow};
  endfunction

  function automatic void m_step(step_t s);
    int sum;
    sum = 0;
    foreach (mcnt[i]) sum += mcnt[i];
    mov = 0;
    if (mstate == 0) begin
      m_clear(); mrdy = 0;
      if (s.en) mstate = 1;
    end else if (!s.en) begin
      m_clear(); mrdy = 0; mstate = 0;
    end else if (mstate == 1 && s.be) begin
      mstate = 2; mrdy = 1;
    end else if (mstate == 1 && s.ar) begin
      if (s.a >= 8'h20 && s.a <= 8'h7E) begin
        if (mcnt[mline] < TL) begin
          mch[mline][mcnt[mline]] = s.a;
          mcnt[mline]++;
        end else mov = 1;
      end else if (s.a == 8'h08) begin
        if (mcnt[mline] > 0) begin
          mcnt[mline]--;
          mch[mline][mcnt[mline]] = 8'h00;
        end else if (mline > 0) mline--;
      end else if (s.a == 8'h0D) begin
        if (mline < NL-1) mline++;
      end else if (s.a == 8'h1B) m_clear();
    end
    mtot = (mstate == 0) ? 0 : sum;
  endfunction

  function automatic step_t k(logic [7:0] a);
    return '{en: 1'b1, be: 1'b0, ar: 1'b1, a: a};
  endfunction

  localparam step_t NOP  = '{en: 1'b1, be: 1'b0, ar: 1'b0, a: 8'h00};
  localparam step_t OFF  = '{en: 1'b0, be: 1'b0, ar: 1'b0, a: 8'h00};
  localparam step_t COMM = '{en: 1'b1, be: 1'b1, ar: 1'b1, a: 8'h5A};

  task automatic drive(input step_t s);
    edit_en      = s.en;
    button_enter = s.be;
    ascii_ready  = s.ar;
    ascii        = s.a;
    m_step(s);
    sb.push_back(m_snap());
    @(posedge clk);
    #1;
    button_enter = 1'b0;
    ascii_ready  = 1'b0;
  endtask

  task automatic test_reset();
    snap_t e;
    rst_n = 1'b0; edit_en = 1'b0; button_enter = 1'b0;
    ascii_ready = 1'b0; ascii = 8'h00;
    m_reset();
    sb.push_back(m_snap());
    repeat (2) @(posedge clk);
    #1;
    e = sb.pop_front();
    n_vec++;
    if (obs() !== e) begin
      n_bad++;
      $display("FAIL reset: got %h want %h", obs(), e);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_type_hi();
    step_t st[$];
    snap_t e;
    st = '{NOP, k(8'h48), k(8'h49), NOP};
    foreach (st[i]) begin
      drive(st[i]);
      e = sb.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL hi[%0d]: got %h want %h", i, obs(), e);
      end
    end
    n_vec++;
    if (char_array[W-1 -: 16] !== 16'h4849 || char_array[W-17:0] !== '0
        || num_char !== 6'd2 || total_char !== 8'd2
        || char_array_rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL hi_const: got %h n=%0d t=%0d want 4849.. n=2 t=2",
               char_array[W-1 -: 16], num_char, total_char);
    end
  endtask

  task automatic test_overflow();
    step_t st[$];
    snap_t e;
    int    ov_n, ov_at;
    ov_n = 0; ov_at = -1;
    st.push_back(k(8'h1B));
    for (int i = 0; i < TL+1; i++) st.push_back(k(8'h61 + 8'(i)));
    st.push_back(NOP);
    foreach (st[i]) begin
      drive(st[i]);
      if (overflow === 1'b1) begin ov_n++; ov_at = i; end
      e = sb.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL ovf[%0d]: got %h want %h", i, obs(), e);
      end
    end
    n_vec++;
    if (ov_n != 1 || ov_at != TL+1 || num_char !== 6'(TL)) begin
      n_bad++;
      $display("FAIL ovf_pulse: got n=%0d at=%0d cnt=%0d want 1 %0d %0d",
               ov_n, ov_at, num_char, TL+1, TL);
    end
  endtask

  task automatic test_backspace();
    step_t st[$];
    snap_t e;
    st = '{k(8'h1B), k(8'h41), k(8'h42), k(8'h08), k(8'h08),
           k(8'h08), NOP};
    foreach (st[i]) begin
      drive(st[i]);
      e = sb.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL bs[%0d]: got %h want %h", i, obs(), e);
      end
    end
    n_vec++;
    if (char_array !== '0 || num_char !== 6'd0 || line_idx !== 2'd0) begin
      n_bad++;
      $display("FAIL bs_const: got n=%0d l=%0d want 0 0",
               num_char, line_idx);
    end
  endtask

  task automatic test_lines_commit();
    step_t st[$];
    snap_t e;
    st = '{k(8'h1B), k(8'h41), k(8'h0D), k(8'h42), k(8'h08), k(8'h08),
           COMM, k(8'h51), k(8'h52), k(8'h0D), NOP};
    foreach (st[i]) begin
      drive(st[i]);
      e = sb.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL lines[%0d]: got %h want %h", i, obs(), e);
      end
    end
    n_vec++;
    if (char_array[W-1 -: 8] !== 8'h41 || char_array[W-9:0] !== '0
        || char_array_rdy !== 1'b1 || line_idx !== 2'd0) begin
      n_bad++;
      $display("FAIL lines_const: got %h rdy=%b l=%0d want 41 1 0",
               char_array[W-1 -: 8], char_array_rdy, line_idx);
    end
  endtask

  task automatic test_drop_en();
    step_t st[$];
    snap_t e;
    st = '{OFF, k(8'h58), NOP};
    foreach (st[i]) begin
      drive(st[i]);
      e = sb.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL drop[%0d]: got %h want %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t st[$];
    snap_t e;
    st = '{k(8'h31), k(8'h32), k(8'h33), k(8'h34), k(8'h35), NOP};
    foreach (st[i]) begin
      drive(st[i]);
      e = sb.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL b2b[%0d]: got %h want %h", i, obs(), e);
      end
    end
    n_vec++;
    if (char_array[W-1 -: 40] !== 40'h3132333435 || total_char !== 8'd5)
    begin
      n_bad++;
      $display("FAIL b2b_const: got %h t=%0d want 3132333435 5",
               char_array[W-1 -: 40], total_char);
    end
  endtask

  task automatic test_async_reset();
    step_t st[$];
    snap_t e;
    edit_en = 1'b1; ascii = 8'h4B; ascii_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    m_reset();
    sb.push_back(m_snap());
    #1;
    e = sb.pop_front();
    n_vec++;
    if (obs() !== e) begin
      n_bad++;
      $display("FAIL async_rst: got %h want %h", obs(), e);
    end
    ascii_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    st = '{NOP, k(8'h4D), NOP};
    foreach (st[i]) begin
      drive(st[i]);
      e = sb.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL rst_edit[%0d]: got %h want %h", i, obs(), e);
      end
    end
    n_vec++;
    if (char_array[W-1 -: 8] !== 8'h4D || char_array[W-9:0] !== '0
        || num_char !== 6'd1) begin
      n_bad++;
      $display("FAIL rst_const: got %h n=%0d want 4D 1",
               char_array[W-1 -: 8], num_char);
    end
  endtask

  initial begin
    test_reset();
    test_type_hi();
    test_overflow();
    test_backspace();
    test_lines_commit();
    test_drop_en();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/custom_text_editor.md
# custom_text_editor

Multi-line, editable successor to the single-line custom text entry block. Takes decoded ASCII bytes from the keyboard front end (`ps2_ascii_input` lives outside this block). Builds NUM_LINES fixed-width, left-justified character lines with backspace, newline and clear-all editing. Hands the committed text to the overlay/text renderer in the ADD_EDITS stage.

## Interface
Parameters:
- TEXT_LEN_MAX, 20, characters per line (1..63)
- NUM_LINES, 2, number of text lines (1..4)
- PAD_CHAR, 8'h00, value held in every unused character slot

Ports:
- clock_27mhz  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- edit_en  in  1  level; high = editing permitted (driven by `fsm_state==ADD_EDITS && custom_text_en`)
- button_enter  in  1  commit request (already debounced/one-pulsed)
- ascii  in  8  keyboard byte
- ascii_ready  in  1  single-cycle strobe qualifying `ascii`
- char_array  out  NUM_LINES*TEXT_LEN_MAX*8  text; line 0 in MSBs; within a line, char 0 in the MSB byte
- char_array_rdy  out  1  high while in DONE
- line_idx  out  2  current line being edited
- num_char  out  6  characters on the current line
- total_char  out  8  characters across all lines
- overflow  out  1  one-cycle pulse when a printable char is dropped because the line is full

## Operation
- Byte slot for line L, index k: `char_array[((NUM_LINES-1-L)*TEXT_LEN_MAX + (TEXT_LEN_MAX-1-k))*8 +: 8]`.
- Per-line counters count[L] are 6 bits wide, range 0..TEXT_LEN_MAX. `num_char = count[line_idx]`. `total_char` is the sum of all counts.
- States: IDLE, EDIT, DONE.
- IDLE:
  - Every cycle: all slots = PAD_CHAR, all counts = 0, line_idx = 0, rdy = 0.
  - edit_en=1 -> EDIT.
- EDIT, on `ascii_ready` (at most one action per cycle):
  - 8'h20..8'h7E, count<MAX: write slot[line][count], count++.
  - 8'h20..8'h7E, count==MAX: byte dropped, overflow pulse.
  - 8'h08 (BS), count>0: count--, slot[line][count-1] = PAD_CHAR.
  - 8'h08 (BS), count==0 and line>0: line_idx--. No character is deleted.
  - 8'h08 (BS), line 0 and count 0: ignored.
  - 8'h0D (CR), line<NUM_LINES-1: line_idx++.
  - 8'h0D (CR) on the last line: ignored.
  - 8'h1B (ESC): all slots PAD_CHAR, all counts 0, line_idx 0. Stay in EDIT.
  - Any other byte: ignored.
- EDIT + button_enter -> DONE.
- DONE:
  - rdy=1; text frozen; ascii_ready and button_enter ignored.
  - edit_en=0 -> IDLE.
- Priority in every state: edit_en=0 (-> IDLE, clear) > button_enter > ascii_ready.
  - So button_enter together with ascii_ready in EDIT commits without applying the byte.
- reset_n low, at any time including mid-edit: immediately state IDLE, all outputs at reset values.

## Timing
- All outputs are registered. Reset values: char_array all PAD_CHAR, char_array_rdy 0, line_idx 0, num_char 0, total_char 0, overflow 0.
- ascii_ready sampled at edge N:
  - char_array, num_char and line_idx all update at edge N (visible cycle N+1). They must be mutually consistent, with no lagging count.
  - total_char is valid one cycle later, at N+1 (pipelined sum).
  - overflow is high exactly the cycle after edge N.
- button_enter at edge N: char_array_rdy high from cycle N+1.
- IDLE->EDIT takes one cycle. A keystroke arriving in the same cycle edit_en rises is dropped.
- edit_en falling at edge N: everything is cleared by cycle N+1.
- Back-to-back ascii_ready strobes, one per cycle, must all be accepted.

## Test plan
- Reset, pulse edit_en, type "HI" (8'h48, 8'h49):
  - line 0 holds 48,49 in the MSB bytes, rest 00.
  - num_char=2, total_char=2, rdy=0.
- Type 21 printable chars into TEXT_LEN_MAX=20:
  - first 20 stored, num_char=20.
  - 21st dropped; overflow high exactly one cycle.
- "AB", BS, BS, BS: num_char 2->1->0, slots return to 00. The third BS on line 0 changes nothing.
- "A", CR, "B", BS, BS, then commit:
  - line_idx goes 0->1; line 1 gets 'B', which is then removed.
  - second BS takes line_idx back to 0; line 0 keeps 'A'.
  - commit gives rdy=1.
  - later keystrokes leave char_array unchanged.
- DONE with text present, then drop edit_en: next cycle all zeros, rdy=0, state IDLE.
- reset_n asserted mid-typing with ascii_ready high: outputs zero immediately (async). After release, edit_en still high re-enters EDIT with an empty buffer.
